// File: rtl/bsg_wormhole_link_arbiter.sv
// Packet-granular round-robin arbiter that merges several wormhole ready-and links onto one.
// Optional per-input header counters are built when BSG_WORMHOLE_LINK_ARBITER_STATS_EN is defined.
module bsg_wormhole_link_arbiter #(
  parameter int els_p         = 3,
  parameter int flit_width_p  = 64,
  parameter int len_width_p   = 4,
  parameter int len_offset_p  = 0,
  parameter int stats_width_p = 16,
  localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [els_p-1:0]                 v_i,
  input  logic [els_p*flit_width_p-1:0]    data_i,
  output logic [els_p-1:0]                 ready_and_o,
  output logic                             v_o,
  output logic [flit_width_p-1:0]          data_o,
  input  logic                             ready_and_i,
  output logic [id_width_lp-1:0]           grant_id_o,
  output logic                             busy_o,
  output logic [els_p*stats_width_p-1:0]   pkt_count_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                  state_r;
  logic [id_width_lp-1:0]  last_r;
  logic [id_width_lp-1:0]  lock_id_r;
  logic [len_width_p-1:0]  remaining_r;

  logic [id_width_lp-1:0]  rr_pick;
  logic [id_width_lp-1:0]  rr_idx;
  logic                    rr_found;
  logic [id_width_lp-1:0]  sel;
  logic [len_width_p-1:0]  len;
  logic                    hs;
  logic [flit_width_p-1:0] flits [els_p];

  for (genvar i = 0; i < els_p; i++) begin : g_unpack
    assign flits[i] = data_i[i*flit_width_p +: flit_width_p];
  end

  // Cyclic search starting just after the last granted input.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_r;
    rr_idx   = '0;
    for (int k = 1; k <= els_p; k++) begin
      rr_idx = id_width_lp'((int'(last_r) + k) % els_p);
      if (!rr_found && v_i[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  assign sel        = (state_r == LOCKED) ? lock_id_r : rr_pick;
  assign v_o        = v_i[sel];
  assign data_o     = flits[sel];
  assign grant_id_o = sel;
  assign busy_o     = (state_r == LOCKED);
  assign hs         = v_o & ready_and_i;
  assign len        = data_o[len_offset_p +: len_width_p];

  // No input is acknowledged while reset is held or when nothing is being offered in IDLE.
  always_comb begin
    ready_and_o = '0;
    if (reset_n_i && ((state_r == LOCKED) || rr_found))
      ready_and_o[sel] = ready_and_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      last_r      <= id_width_lp'(els_p - 1);
      lock_id_r   <= '0;
      remaining_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs) begin
            if (len == '0) begin
              last_r <= sel;
            end else begin
              state_r     <= LOCKED;
              lock_id_r   <= sel;
              remaining_r <= len;
            end
          end
        end
        LOCKED: begin
          if (hs) begin
            remaining_r <= remaining_r - len_width_p'(1);
            if (remaining_r == len_width_p'(1)) begin
              state_r <= IDLE;
              last_r  <= lock_id_r;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef BSG_WORMHOLE_LINK_ARBITER_STATS_EN
  logic [stats_width_p-1:0] count_r [els_p];

  // Every IDLE handshake is a header, whatever its length; counters saturate.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) count_r[i] <= '0;
    end else if (hs && (state_r == IDLE) && (count_r[sel] != '1)) begin
      count_r[sel] <= count_r[sel] + stats_width_p'(1);
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_stats
    assign pkt_count_o[i*stats_width_p +: stats_width_p] = count_r[i];
  end
`else
  assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_wormhole_link_arbiter.sv
// Directed bench for bsg_wormhole_link_arbiter: per-input source queues, expected-flit scoreboard,
// hand-ordered packet sequences and optional counter checks.
module tb_bsg_wormhole_link_arbiter;

  localparam int els_p         = 3;
  localparam int flit_width_p  = 64;
  localparam int len_width_p   = 4;
  localparam int stats_width_p = 16;
  localparam int id_width      = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk = ~clk;

  logic [els_p-1:0]               v_i;
  logic [els_p*flit_width_p-1:0]  data_i;
  logic [els_p-1:0]               ready_and_o;
  logic                           v_o;
  logic [flit_width_p-1:0]        data_o;
  logic                           ready_and_i;
  logic [id_width-1:0]            grant_id_o;
  logic                           busy_o;
  logic [els_p*stats_width_p-1:0] pkt_count_o;

  bsg_wormhole_link_arbiter #(
    .els_p(els_p), .flit_width_p(flit_width_p), .len_width_p(len_width_p),
    .len_offset_p(0), .stats_width_p(stats_width_p)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .pkt_count_o(pkt_count_o)
  );

  // scoreboard state
  logic [flit_width_p-1:0] exp_q[$];
  logic [flit_width_p-1:0] q0[$];
  logic [flit_width_p-1:0] q1[$];
  logic [flit_width_p-1:0] q2[$];
  int cnt_model [els_p];
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Flit layout: [63:56]=8'hA0+src, [55:48]=pkt, [47:40]=flit index, [3:0]=len (body flits carry 4'hF there).
  function automatic logic [63:0] mk(input int src, input int pkt, input int idx, input int len);
    logic [63:0] f;
    f = '0;
    f[63:56] = 8'(8'hA0 + src);
    f[55:48] = 8'(pkt);
    f[47:40] = 8'(idx);
    f[3:0]   = (idx == 0) ? 4'(len) : 4'hF;
    return f;
  endfunction

  task automatic add_pkt(input int src, input int pkt, input int len);
    for (int i = 0; i <= len; i++) begin
      case (src)
        0: q0.push_back(mk(src, pkt, i, len));
        1: q1.push_back(mk(src, pkt, i, len));
        default: q2.push_back(mk(src, pkt, i, len));
      endcase
    end
  endtask

  task automatic expect_pkt(input int src, input int pkt, input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back(mk(src, pkt, i, len));
  endtask

  // driver: present queue heads, then let combinational outputs settle
  task automatic drive(input logic rdy);
    ready_and_i = rdy;
    v_i = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    data_i = '0;
    if (q0.size() != 0) data_i[0*flit_width_p +: flit_width_p] = q0[0];
    if (q1.size() != 0) data_i[1*flit_width_p +: flit_width_p] = q1[0];
    if (q2.size() != 0) data_i[2*flit_width_p +: flit_width_p] = q2[0];
    #1;
  endtask

  // compare any transfer of this cycle, then clock it and retire accepted flits
  task automatic tick();
    logic [els_p-1:0] pop;
    logic [63:0] e;
    int src;
    pop = v_i & ready_and_o;
    if (v_o && ready_and_i) begin
      if (exp_q.size() == 0) begin
        check("extra_flit", data_o, 64'h0);
      end else begin
        e = exp_q.pop_front();
        src = int'(e[57:56]);
        check("data", data_o, e);
        check("grant", 64'(grant_id_o), 64'(src));
        check("busy", 64'(busy_o), 64'(e[47:40] != 8'd0));
        check("ready", 64'(ready_and_o), 64'(1 << src));
        if (e[47:40] == 8'd0 && cnt_model[src] != 65535) cnt_model[src]++;
      end
    end
    @(posedge clk);
    #1;
    if (pop[0] && q0.size() != 0) void'(q0.pop_front());
    if (pop[1] && q1.size() != 0) void'(q1.pop_front());
    if (pop[2] && q2.size() != 0) void'(q2.pop_front());
  endtask

  task automatic drain(input int max_cycles);
    for (int n = 0; n < max_cycles && exp_q.size() != 0; n++) begin
      drive(1'b1);
      tick();
    end
    check("drain_exp", 64'(exp_q.size()), 64'd0);
    check("drain_src", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < els_p; i++) begin
`ifdef BSG_WORMHOLE_LINK_ARBITER_STATS_EN
      check(tag, 64'(pkt_count_o[i*stats_width_p +: stats_width_p]), 64'(cnt_model[i]));
`else
      check(tag, 64'(pkt_count_o[i*stats_width_p +: stats_width_p]), 64'd0);
`endif
    end
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    exp_q.delete(); q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < els_p; i++) cnt_model[i] = 0;
    drive(1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset_n_i = 1'b1;
    #1;
  endtask

  initial begin
    v_i = '0; data_i = '0; ready_and_i = 1'b0;
    do_reset();

    // reset state with nothing offered
    drive(1'b1);
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_ready", 64'(ready_and_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check_counts("rst_count");

    // single-flit packet on input 0, zero latency
    add_pkt(0, 1, 0); expect_pkt(0, 1, 0);
    drive(1'b1);
    check("t1_v", 64'(v_o), 64'd1);
    check("t1_data", data_o, mk(0, 1, 0, 0));
    check("t1_ready", 64'(ready_and_o), 64'b001);
    check("t1_busy", 64'(busy_o), 64'd0);
    tick();
    drain(5);
    check_counts("t1_count");

    // three len=2 packets: 0,0,0,1,1,1,2,2,2
    do_reset();
    add_pkt(0, 2, 2); add_pkt(1, 2, 2); add_pkt(2, 2, 2);
    expect_pkt(0, 2, 2); expect_pkt(1, 2, 2); expect_pkt(2, 2, 2);
    drain(30);
    check_counts("t2_count");

    // input 1 locked with back-pressure while input 0 waits
    do_reset();
    add_pkt(1, 3, 3);
    expect_pkt(1, 3, 3); expect_pkt(0, 3, 0);
    drive(1'b1); tick();
    drive(1'b1); tick();
    add_pkt(0, 3, 0);
    drive(1'b1); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0);
      check("t3_hold_grant", 64'(grant_id_o), 64'd1);
      check("t3_hold_busy", 64'(busy_o), 64'd1);
      check("t3_hold_ready", 64'(ready_and_o), 64'd0);
      check("t3_hold_v", 64'(v_o), 64'd1);
      tick();
    end
    drive(1'b1);
    check("t3_last_grant", 64'(grant_id_o), 64'd1);
    tick();
    drain(10);

    // inputs 1 and 2 alternate; input 0 joins and gets the next slot
    do_reset();
    for (int p = 0; p < 4; p++) begin
      add_pkt(1, 4 + p, 0);
      add_pkt(2, 4 + p, 0);
    end
    expect_pkt(1, 4, 0); expect_pkt(2, 4, 0); expect_pkt(1, 5, 0); expect_pkt(2, 5, 0);
    expect_pkt(0, 9, 0);
    expect_pkt(1, 6, 0); expect_pkt(2, 6, 0); expect_pkt(1, 7, 0); expect_pkt(2, 7, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1); tick();
    end
    add_pkt(0, 9, 0);
    drain(20);
    check_counts("t4_count");

    // asynchronous reset while locked on input 2
    do_reset();
    add_pkt(2, 10, 3); expect_pkt(2, 10, 3);
    drive(1'b1); tick();
    drive(1'b1); tick();
    drive(1'b1);
    check("t5_pre_busy", 64'(busy_o), 64'd1);
    reset_n_i = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy_o), 64'd0);
    check("t5_rst_ready", 64'(ready_and_o), 64'd0);
    do_reset();
    add_pkt(0, 11, 0); add_pkt(1, 11, 0); add_pkt(2, 11, 0);
    drive(1'b1);
    check("t5_first_grant", 64'(grant_id_o), 64'd0);
    expect_pkt(0, 11, 0); expect_pkt(1, 11, 0); expect_pkt(2, 11, 0);
    drain(10);
    check_counts("t5_count");

`ifdef BSG_WORMHOLE_LINK_ARBITER_STATS_EN
    // five packets on input 2
    do_reset();
    for (int p = 0; p < 5; p++) begin
      add_pkt(2, 20 + p, p % 2);
      expect_pkt(2, 20 + p, p % 2);
    end
    drain(30);
    check("st_cnt0", 64'(pkt_count_o[0 +: 16]), 64'd0);
    check("st_cnt1", 64'(pkt_count_o[16 +: 16]), 64'd0);
    check("st_cnt2", 64'(pkt_count_o[32 +: 16]), 64'd5);

    // saturation on input 0
    do_reset();
    ready_and_i = 1'b1;
    v_i = 3'b001;
    data_i = '0;
    data_i[0 +: 64] = mk(0, 30, 0, 0);
    repeat (65540) @(posedge clk);
    #1;
    check("st_sat", 64'(pkt_count_o[0 +: 16]), 64'hFFFF);
    check("st_sat_other", 64'(pkt_count_o[16 +: 32]), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
